// File: rtl/ipf_pkg.sv
// Shared types and constants for the IPF LCU scheduler: FSM states,
// LCU size decode and the parameter-word field layout.
package ipf_pkg;

    localparam int unsigned IMG_W  = 128;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned PAR_W  = 24;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned LCU_W  = 3;
    localparam int unsigned IDX_W  = 6;

    // Parameter word: {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}
    localparam int unsigned TYPE_MSB  = 23;
    localparam int unsigned TYPE_LSB  = 22;
    localparam int unsigned BAND_MSB  = 21;
    localparam int unsigned BAND_LSB  = 17;
    localparam int unsigned CLASS_BIT = 16;
    localparam int unsigned OFF_MSB   = 15;
    localparam int unsigned OFF_LSB   = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRM,
        S_PLD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // Pixels per LCU side minus one
    function automatic logic [CNT_W-1:0] size_n_m1(input logic [1:0] size);
        case (size)
            2'd0:    return CNT_W'(15);
            2'd1:    return CNT_W'(31);
            default: return CNT_W'(63);
        endcase
    endfunction

    // LCUs per image side minus one
    function automatic logic [CNT_W-1:0] size_l_m1(input logic [1:0] size);
        case (size)
            2'd0:    return CNT_W'(7);
            2'd1:    return CNT_W'(3);
            default: return CNT_W'(1);
        endcase
    endfunction

    function automatic logic [1:0] size_norm(input logic [1:0] size);
        return (size == 2'd3) ? 2'd2 : size;
    endfunction

endpackage

// File: rtl/ipf_lcu_addr_gen.sv
// Pixel/LCU raster counters: col, row inside an LCU, lx, ly across the image.
// Produces the image address, LCU index and the wrap flags the scheduler needs.
module ipf_lcu_addr_gen
    import ipf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [1:0]        size,
    output logic [ADDR_W-1:0] img_addr,
    output logic [IDX_W-1:0]  par_addr,
    output logic [LCU_W-1:0]  lcu_x,
    output logic [LCU_W-1:0]  lcu_y,
    output logic              first_in_row,
    output logic              first_row,
    output logic              last_in_row,
    output logic              last_row,
    output logic              last_lcu,
    output logic              last_pixel
);

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] lx;
    logic [CNT_W-1:0] ly;
    logic [CNT_W-1:0] n_m1;
    logic [CNT_W-1:0] l_m1;
    logic             last_lx;
    logic             last_ly;

    assign n_m1         = size_n_m1(size);
    assign l_m1         = size_l_m1(size);
    assign first_in_row = (col == '0);
    assign first_row    = (row == '0);
    assign last_in_row  = (col == n_m1);
    assign last_row     = (row == n_m1);
    assign last_lx      = (lx == l_m1);
    assign last_ly      = (ly == l_m1);
    assign last_lcu     = last_lx && last_ly;
    assign last_pixel   = last_in_row && last_row && last_lcu;
    assign lcu_x        = lx[LCU_W-1:0];
    assign lcu_y        = ly[LCU_W-1:0];

    // Nested wrap: col -> row -> lx -> ly; the final pixel returns everything to 0
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col <= '0;
            row <= '0;
            lx  <= '0;
            ly  <= '0;
        end else if (advance) begin
            if (!last_in_row) begin
                col <= col + CNT_W'(1);
            end else begin
                col <= '0;
                if (!last_row) begin
                    row <= row + CNT_W'(1);
                end else begin
                    row <= '0;
                    if (!last_lx) begin
                        lx <= lx + CNT_W'(1);
                    end else begin
                        lx <= '0;
                        ly <= last_ly ? '0 : ly + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Address = {ly, row, lx, col} with field widths set by the LCU size
    always_comb begin
        img_addr = '0;
        par_addr = '0;
        case (size)
            2'd0: begin
                img_addr = {ly[2:0], row[3:0], lx[2:0], col[3:0]};
                par_addr = {ly[2:0], lx[2:0]};
            end
            2'd1: begin
                img_addr = {ly[1:0], row[4:0], lx[1:0], col[4:0]};
                par_addr = {2'b00, ly[1:0], lx[1:0]};
            end
            default: begin
                img_addr = {ly[0], row, lx[0], col};
                par_addr = {4'b0000, ly[0], lx[0]};
            end
        endcase
    end

endmodule

// File: rtl/ipf_lcu_sched.sv
// Frame scheduler for the IPF filter: streams a 128x128 image in LCU raster
// order with per-LCU parameters prefetched during each LCU's last row.
module ipf_lcu_sched
    import ipf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        lcu_size,
    input  logic              ipf_busy,
    output logic              img_rd,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [PIX_W-1:0]  img_data,
    output logic              par_rd,
    output logic [IDX_W-1:0]  par_addr,
    input  logic [PAR_W-1:0]  par_data,
    output logic              in_en,
    output logic [PIX_W-1:0]  din,
    output logic [LCU_W-1:0]  lcu_x,
    output logic [LCU_W-1:0]  lcu_y,
    output logic [1:0]        lcu_size_o,
    output logic [1:0]        ipf_type,
    output logic [4:0]        ipf_band_pos,
    output logic              ipf_wo_class,
    output logic [15:0]       ipf_offset,
    output logic              done
);

    state_t             state;
    state_t             state_nx;
    logic               start_acc;
    logic [1:0]         size_q;
    logic               par_pend;
    logic [PAR_W-1:0]   shadow;

    logic [ADDR_W-1:0]  g_img_addr;
    logic [IDX_W-1:0]   g_par_addr;
    logic [LCU_W-1:0]   g_lcu_x;
    logic [LCU_W-1:0]   g_lcu_y;
    logic               g_first_in_row;
    logic               g_first_row;
    logic               g_last_in_row;
    logic               g_last_row;
    logic               g_last_lcu;
    logic               g_last_pixel;
    logic               unused_ok;

    ipf_lcu_addr_gen u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .clear        (start_acc),
        .advance      (img_rd),
        .size         (size_q),
        .img_addr     (g_img_addr),
        .par_addr     (g_par_addr),
        .lcu_x        (g_lcu_x),
        .lcu_y        (g_lcu_y),
        .first_in_row (g_first_in_row),
        .first_row    (g_first_row),
        .last_in_row  (g_last_in_row),
        .last_row     (g_last_row),
        .last_lcu     (g_last_lcu),
        .last_pixel   (g_last_pixel)
    );

    assign unused_ok  = g_last_in_row;
    assign img_addr   = g_img_addr;
    assign lcu_size_o = size_q;
    assign din        = in_en ? img_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus the read strobes, which must react to busy in the same cycle
    always_comb begin
        state_nx  = state;
        start_acc = 1'b0;
        img_rd    = 1'b0;
        par_rd    = 1'b0;
        par_addr  = '0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nx  = S_PRM;
                end
            end
            S_PRM: begin
                par_rd   = 1'b1;
                state_nx = S_PLD;
            end
            S_PLD: begin
                state_nx = S_STREAM;
            end
            S_STREAM: begin
                if (!ipf_busy) begin
                    img_rd = 1'b1;
                    // Prefetch the next LCU's parameters at the start of this LCU's last row
                    if (g_last_row && g_first_in_row && !g_last_lcu) begin
                        par_rd   = 1'b1;
                        par_addr = g_par_addr + IDX_W'(1);
                    end
                    if (g_last_pixel) begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_nx = S_DONE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Output and shadow registers; LCU tags switch with the first pixel's in_en
    always_ff @(posedge clk) begin
        if (reset) begin
            size_q       <= '0;
            par_pend     <= 1'b0;
            shadow       <= '0;
            in_en        <= 1'b0;
            done         <= 1'b0;
            lcu_x        <= '0;
            lcu_y        <= '0;
            ipf_type     <= '0;
            ipf_band_pos <= '0;
            ipf_wo_class <= 1'b0;
            ipf_offset   <= '0;
        end else begin
            if (start_acc) begin
                size_q <= size_norm(lcu_size);
            end
            par_pend <= par_rd;
            if (par_pend) begin
                shadow <= par_data;
            end
            in_en <= img_rd;
            done  <= (state_nx == S_DONE);
            if (img_rd && g_first_in_row && g_first_row) begin
                lcu_x        <= g_lcu_x;
                lcu_y        <= g_lcu_y;
                ipf_type     <= shadow[TYPE_MSB:TYPE_LSB];
                ipf_band_pos <= shadow[BAND_MSB:BAND_LSB];
                ipf_wo_class <= shadow[CLASS_BIT];
                ipf_offset   <= shadow[OFF_MSB:OFF_LSB];
            end
        end
    end

endmodule

// File: tb/tb_ipf_lcu_sched.sv
// Self-checking bench for ipf_lcu_sched: random image/parameter memories and
// a pixel-index reference model of the LCU raster walk.
module tb_ipf_lcu_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  lcu_size;
    logic        ipf_busy;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_data;
    logic        par_rd;
    logic [5:0]  par_addr;
    logic [23:0] par_data;
    logic        in_en;
    logic [7:0]  din;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size_o;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic        done;

    logic [7:0]  img_mem [16384];
    logic [23:0] par_mem [64];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ipf_lcu_sched dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .lcu_size     (lcu_size),
        .ipf_busy     (ipf_busy),
        .img_rd       (img_rd),
        .img_addr     (img_addr),
        .img_data     (img_data),
        .par_rd       (par_rd),
        .par_addr     (par_addr),
        .par_data     (par_data),
        .in_en        (in_en),
        .din          (din),
        .lcu_x        (lcu_x),
        .lcu_y        (lcu_y),
        .lcu_size_o   (lcu_size_o),
        .ipf_type     (ipf_type),
        .ipf_band_pos (ipf_band_pos),
        .ipf_wo_class (ipf_wo_class),
        .ipf_offset   (ipf_offset),
        .done         (done)
    );

    // Host memories: read data valid one cycle after the strobe
    always @(posedge clk) begin
        if (img_rd) img_data <= img_mem[img_addr];
        if (par_rd) par_data <= par_mem[par_addr];
    end

    // Image address of the p-th pixel in LCU raster / row-major order
    function automatic int pix_addr(input int p, input int n);
        int l;
        int k;
        int q;
        l = 128 / n;
        k = p / (n * n);
        q = p % (n * n);
        return ((k / l) * n + q / n) * 128 + (k % l) * n + q % n;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 16384; i++) img_mem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) par_mem[i] = 24'($urandom);
    endtask

    // One frame, compared cycle by cycle against the pixel-index model
    task automatic run_frame(input logic [1:0] sz, input int busy_at, input int busy_len,
                             input bit rnd_busy, input int restart_at, input int stop_after,
                             input string tag);
        int eff, n, l, ppl, nl, k, want_pa;
        int model_rd = 0;
        int prev_idx = 0;
        int busy_cnt = 0;
        int done_cyc = -1;
        int n_en = 0;
        int n_par = 0;
        bit prev_rd = 1'b0;
        bit exp_rd, exp_par, exp_done, busy;
        eff = (sz == 2'd3) ? 2 : int'(sz);
        n   = 16 << eff;
        l   = 128 / n;
        ppl = n * n;
        nl  = l * l;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            @(negedge clk);
            start    = (cyc == 0) || (cyc == restart_at);
            lcu_size = (cyc == 0) ? sz : 2'($urandom);
            busy     = 1'b0;
            if (busy_at >= 0 && model_rd == busy_at && busy_cnt < busy_len) begin
                busy = 1'b1;
                busy_cnt++;
            end else if (rnd_busy && $urandom_range(15, 0) == 0) begin
                busy = 1'b1;
            end
            ipf_busy = busy;
            #1;
            exp_rd  = (cyc >= 3) && (model_rd < 16384) && !busy;
            exp_par = (cyc == 1) ||
                      (exp_rd && (model_rd % ppl) == (n - 1) * n && (model_rd / ppl) < nl - 1);
            want_pa = (cyc == 1) ? 0 : model_rd / ppl + 1;

            n_cmp++;
            if (img_rd !== exp_rd) begin
                n_fail++;
                $display("FAIL %s img_rd cyc=%0d got=%b want=%b", tag, cyc, img_rd, exp_rd);
            end
            if (exp_rd) begin
                n_cmp++;
                if (img_addr !== 14'(pix_addr(model_rd, n))) begin
                    n_fail++;
                    $display("FAIL %s img_addr pix=%0d got=%0d want=%0d", tag, model_rd,
                             img_addr, pix_addr(model_rd, n));
                end
            end
            n_cmp++;
            if (par_rd !== exp_par) begin
                n_fail++;
                $display("FAIL %s par_rd cyc=%0d got=%b want=%b", tag, cyc, par_rd, exp_par);
            end
            if (exp_par) begin
                n_cmp++;
                if (par_addr !== 6'(want_pa)) begin
                    n_fail++;
                    $display("FAIL %s par_addr cyc=%0d got=%0d want=%0d", tag, cyc, par_addr, want_pa);
                end
            end
            if (par_rd) n_par++;
            n_cmp++;
            if (in_en !== prev_rd) begin
                n_fail++;
                $display("FAIL %s in_en cyc=%0d got=%b want=%b", tag, cyc, in_en, prev_rd);
            end
            if (prev_rd) begin
                n_en++;
                k = prev_idx / ppl;
                n_cmp++;
                if (din !== img_mem[pix_addr(prev_idx, n)]) begin
                    n_fail++;
                    $display("FAIL %s din pix=%0d got=%0h want=%0h", tag, prev_idx, din,
                             img_mem[pix_addr(prev_idx, n)]);
                end
                n_cmp++;
                if ({lcu_y, lcu_x} !== {3'(k / l), 3'(k % l)}) begin
                    n_fail++;
                    $display("FAIL %s lcu_xy pix=%0d got=%0d,%0d want=%0d,%0d", tag, prev_idx,
                             lcu_x, lcu_y, k % l, k / l);
                end
                n_cmp++;
                if ({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset} !== par_mem[k]) begin
                    n_fail++;
                    $display("FAIL %s ipf_params pix=%0d got=%0h want=%0h", tag, prev_idx,
                             {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}, par_mem[k]);
                end
                if (prev_idx == 16383) done_cyc = cyc;
            end
            exp_done = (done_cyc >= 0) && (cyc > done_cyc);
            if (cyc >= 1) begin
                n_cmp++;
                if (done !== exp_done) begin
                    n_fail++;
                    $display("FAIL %s done cyc=%0d got=%b want=%b", tag, cyc, done, exp_done);
                end
                n_cmp++;
                if (lcu_size_o !== 2'(eff)) begin
                    n_fail++;
                    $display("FAIL %s lcu_size_o got=%0d want=%0d", tag, lcu_size_o, eff);
                end
            end
            prev_rd  = exp_rd;
            prev_idx = model_rd;
            if (exp_rd) model_rd++;
            if (stop_after >= 0 && model_rd >= stop_after) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (n_fail > 40) break;
        end
        start = 1'b0;
        ipf_busy = 1'b0;
        if (stop_after < 0) begin
            n_cmp++;
            if (done_cyc < 0) begin
                n_fail++;
                $display("FAIL %s frame_timeout got=no_done want=done", tag);
            end
            n_cmp++;
            if (n_en != 16384) begin
                n_fail++;
                $display("FAIL %s in_en_count got=%0d want=16384", tag, n_en);
            end
            n_cmp++;
            if (n_par != nl) begin
                n_fail++;
                $display("FAIL %s par_rd_count got=%0d want=%0d", tag, n_par, nl);
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b1;
        lcu_size = 2'd1;
        ipf_busy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({img_rd, img_addr, par_rd, par_addr, in_en, din, lcu_x, lcu_y, lcu_size_o,
             ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, done} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got=nonzero want=0");
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({img_rd, par_rd, in_en, done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_quiet got=%b want=0000", {img_rd, par_rd, in_en, done});
            end
        end
    endtask

    task automatic test_size64_restart_ignored();
        run_frame(2'd2, -1, 0, 1'b0, 2000, -1, "sz64");
    endtask

    task automatic test_size16_from_done();
        run_frame(2'd0, -1, 0, 1'b0, -1, -1, "sz16_done");
    endtask

    task automatic test_busy_size3();
        run_frame(2'd3, 777, 5, 1'b1, -1, -1, "busy_sz3");
    endtask

    task automatic test_abort_and_restart();
        run_frame(2'($urandom_range(2, 0)), -1, 0, 1'b0, -1, 5000, "abort");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({img_rd, img_addr, par_rd, par_addr, in_en, din, lcu_x, lcu_y, lcu_size_o,
             ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, done} !== 64'h0) begin
            n_fail++;
            $display("FAIL abort_outputs got=nonzero want=0");
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({img_rd, par_rd, in_en, done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL abort_idle got=%b want=0000", {img_rd, par_rd, in_en, done});
            end
        end
        run_frame(2'd1, -1, 0, 1'b0, -1, -1, "sz32_after_abort");
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_size64_restart_ignored();
        test_size16_from_done();
        test_busy_size3();
        test_abort_and_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ipf_lcu_sched.md
Name: ipf_lcu_sched

Overview:
- Frame-level scheduler that feeds the IPF filter datapath.
- Walks every LCU of a 128x128 8-bit image in LCU raster order, and each LCU's pixels in row-major order.
- Per pixel: reads the image memory and drives in_en/din. Per LCU: fetches parameters from a parameter memory and drives lcu_x/lcu_y/ipf_* so the filter sees a continuous, correctly tagged stream.
- Sits between the testbench/host memories and the filter core; honours the core's busy back-pressure.

Parameters:
- IMG_W, 128, image width and height in pixels (square image).
- ADDR_W, 14, image address width, log2(IMG_W*IMG_W).
- PAR_W, 24, parameter word width, packed as {ipf_type[1:0], ipf_band_pos[4:0], ipf_wo_class, ipf_offset[15:0]} MSB first.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when in IDLE or DONE.
- lcu_size  in  2  0=16, 1=32, 2=64 px LCU; sampled at the accepted start; 3 is treated as 2.
- ipf_busy  in  1  filter back-pressure.
- img_rd  out  1  image read strobe.
- img_addr  out  14  pixel address = y*128+x.
- img_data  in  8  read data, valid exactly 1 cycle after img_rd.
- par_rd  out  1  parameter read strobe.
- par_addr  out  6  LCU index = lcu_y*(128/size)+lcu_x.
- par_data  in  24  parameter word, valid 1 cycle after par_rd.
- in_en  out  1  pixel valid to filter.
- din  out  8  pixel to filter.
- lcu_x, lcu_y  out  3 each  current LCU coordinates.
- lcu_size_o  out  2  latched size.
- ipf_type  out  2; ipf_band_pos  out  5; ipf_wo_class  out  1; ipf_offset  out  16  current LCU parameters.
- done  out  1  frame complete.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs 0, counters 0. Reset mid-frame aborts immediately; no further strobes.
- Geometry: N = 16/32/64, L = 128/N = 8/4/2.
  - Counters col, row (0..N-1) and lx, ly (0..L-1).
  - img_addr = {ly,row,lx,col}, field widths set by size: size 0 → 3+4+3+4; size 1 → 2+5+2+5; size 2 → 1+6+1+6.
- FSM states:
  - IDLE: start → PRM; latch lcu_size.
  - PRM: par_rd=1, par_addr=0 for one cycle → PLD.
  - PLD: capture par_data into the shadow register → STREAM.
  - STREAM: one img_rd per cycle unless ipf_busy; last pixel of last LCU issued → DRAIN.
  - DRAIN: one cycle for the in-flight data → DONE.
  - DONE: done=1 held; start → PRM, with done cleared in the same cycle.
  - start is ignored in PRM/PLD/STREAM/DRAIN.
- Stream timing:
  - in_en(t+1) = img_rd(t); din(t+1) = img_data(t+1).
  - Gap-free in_en across LCU boundaries when ipf_busy=0. Frame latency: start at cycle 0 → par_rd at cycle 1 → first img_rd at cycle 3 → first in_en at cycle 4.
- Parameter prefetch:
  - par_rd for LCU k+1 is asserted in the cycle that issues the first pixel read of LCU k's last row (never on the final LCU). par_data is captured into the shadow register the next cycle.
  - lcu_x/lcu_y/ipf_* outputs update from the shadow register in the same cycle as in_en of that LCU's first pixel, and hold for all N*N pixels.
- Back-pressure:
  - If ipf_busy=1 in a cycle, img_rd=0 that cycle and no counter advances.
  - A read issued the previous cycle still completes: in_en=1 with its data.
  - Busy on the final pixel delays DRAIN by the stall length.
- Wrap order:
  - col wraps to 0 and row increments.
  - row wraps to 0 and lx increments.
  - lx wraps to 0 and ly increments.
  - Last pixel when col=row=N-1 and lx=ly=L-1.
- Width rules: all counters are 6-bit; compares use N-1 derived from the latched size only.

Decomposition:
- Package ipf_pkg holds:
  - state enum;
  - size decode constants (N-1 per size, L-1 per size);
  - parameter-word field offsets (TYPE_MSB=23, BAND=21:17, CLASS=16, OFF=15:0);
  - IMG_W.
- One sub-module, ipf_lcu_addr_gen: col/row/lx/ly counters with advance enable; outputs img_addr, par_addr, last_in_row, last_row, last_lcu, last_pixel.
- The FSM, prefetch and output registers stay in the top module.

Test Plan:
- Size 2, memories preloaded with pixel=addr[7:0] and distinct parameter words, start → exactly 16384 in_en pulses with no gaps. First four addresses are 0,1,2,…; the address after 63 is 128. LCU 1 begins at address 64; par_rd pulses 4 times; done rises 1 cycle after the last in_en.
- Size 0 → 64 par_rd with par_addr 0..63 in order. lcu_x/lcu_y change exactly on the first in_en of each LCU. The 17th pixel read is address 128 (row 1, col 0 of LCU 0).
- ipf_busy high for 5 cycles mid-LCU → img_rd low for those 5 cycles, at most one trailing in_en, and no address skipped or repeated. Total in_en count is still 16384.
- start pulsed again during STREAM → ignored, and the address sequence is unchanged. start in DONE → done clears and par_addr=0 is read again.
- Reset asserted at pixel 5000 → next cycle all outputs 0 and state IDLE. A new start with size 1 gives a clean frame of 16 LCUs.
- lcu_size=3 at start → behaves identically to size 2 (4 LCUs), and lcu_size_o=2.
